// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: data-memory req/gnt/rvalid bus between the LSU (master) and memory (slave)
interface lsu_mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  modport master (output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                  input dmem_gnt, dmem_rvalid, dmem_rdata);
  modport slave (input dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                 output dmem_gnt, dmem_rvalid, dmem_rdata);
endinterface

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: one data-memory transaction per load/store, load alignment/extension and writeback select
module lsu_mem_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TW = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic        su,
  input  logic [1:0]  whb,
  input  logic [1:0]  wos,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [31:0] imm,
  input  logic [31:0] PC_4,
  lsu_mem_stage_if.master dmem,
  output logic [31:0] Data_WB,
  output logic        wb_valid,
  output logic        stall,
  output logic        err_misaligned,
  output logic        err_timeout
);
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [TW-1:0] cnt, cnt_n;
  logic wb_n, mis_n, to_n, lat;
  logic [31:0] wbd_n;
  logic st_q, su_q;
  logic [1:0] whb_q, wos_q;
  logic [3:0] be_q;
  logic [31:0] addr_q, wdata_q, imm_q, pc4_q;
  logic unused_func3;
  assign unused_func3 = ^func3;
  function automatic logic [31:0] wb_sel(input logic [1:0] w, input logic [31:0] a, l, p, i);
    return w == 2'b00 ? a : w == 2'b01 ? l : w == 2'b10 ? p : i;
  endfunction
  logic [1:0] k;
  logic mem_op, misaligned;
  logic [3:0] be_in;
  assign k = alu_result[1:0];
  assign mem_op = opcode == OP_LD || opcode == OP_ST;
  assign misaligned = (whb == 2'b01 && k[0]) || (whb[1] && k != 2'b00);
  assign be_in = whb[1] ? 4'b1111 : whb[0] ? 4'b0011 << k : 4'b0001 << k;
  // whb = 11 falls into the word path, so its lane is always unshifted
  logic [31:0] lane, ext, ld_wb;
  assign lane = dmem.dmem_rdata >> {addr_q[1:0], 3'b000};
  assign ext = whb_q == 2'b00 ? {{24{su_q & lane[7]}}, lane[7:0]} :
               whb_q == 2'b01 ? {{16{su_q & lane[15]}}, lane[15:0]} : lane;
  assign ld_wb = st_q ? '0 : wb_sel(wos_q, addr_q, ext, pc4_q, imm_q);
  assign stall = state == REQ || state == WAIT;
  assign dmem.dmem_req = state == REQ;
  assign dmem.dmem_we = dmem.dmem_req & st_q;
  assign dmem.dmem_addr = dmem.dmem_req ? {addr_q[31:2], 2'b00} : '0;
  assign dmem.dmem_be = dmem.dmem_req ? be_q : '0;
  assign dmem.dmem_wdata = dmem.dmem_req ? wdata_q : '0;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    wb_n = 1'b0;
    wbd_n = Data_WB;
    mis_n = 1'b0;
    to_n = 1'b0;
    lat = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (!mem_op) begin
          wb_n = 1'b1;
          wbd_n = wb_sel(wos, alu_result, '0, PC_4, imm);
        end else if (misaligned) begin
          wb_n = 1'b1;
          wbd_n = '0;
          mis_n = 1'b1;
        end else begin
          lat = 1'b1;
          cnt_n = '0;
          state_n = REQ;
        end
      end
      REQ, WAIT: begin
        // a grant with same-cycle rvalid skips WAIT entirely
        if (state == REQ ? dmem.dmem_gnt && dmem.dmem_rvalid : dmem.dmem_rvalid) begin
          state_n = DONE;
          wb_n = 1'b1;
          wbd_n = ld_wb;
        end else if (state == REQ && dmem.dmem_gnt) begin
          state_n = WAIT;
          cnt_n = '0;
        end else if (cnt == LAST) begin
          state_n = IDLE;
          wb_n = 1'b1;
          wbd_n = '0;
          to_n = 1'b1;
        end else begin
          cnt_n = cnt + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      Data_WB <= '0;
      wb_valid <= 1'b0;
      err_misaligned <= 1'b0;
      err_timeout <= 1'b0;
      st_q <= 1'b0;
      su_q <= 1'b0;
      whb_q <= '0;
      wos_q <= '0;
      be_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      imm_q <= '0;
      pc4_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      Data_WB <= wbd_n;
      wb_valid <= wb_n;
      err_misaligned <= mis_n;
      err_timeout <= to_n;
      if (lat) begin
        st_q <= opcode == OP_ST;
        su_q <= su;
        whb_q <= whb;
        wos_q <= wos;
        be_q <= be_in;
        addr_q <= alu_result;
        wdata_q <= store_data << {k, 3'b000};
        imm_q <= imm;
        pc4_q <= PC_4;
      end
    end
  end
endmodule
